// File: rtl/projectile_launcher.sv
`timescale 1ns/1ps
// projectile_launcher: owns the single player projectile (launch, climb, retire, cooldown, re-arm).
// Latency: fire sampled on edge N launches on edge N+2; hit retires on the same edge it is seen.
// Backpressure: none; presses outside IDLE are dropped. Optional PROJECTILE_AUTOFIRE_EN re-launches while fire is held.
module projectile_launcher #(
    parameter int SPEED          = 4,
    parameter int TOP_Y          = 0,
    parameter int SPAWN_OFS      = 12,
    parameter int COOLDOWN_TICKS = 8,
    parameter int PARK_X         = 0,
    parameter int PARK_Y         = 0
) (
    input  logic       i_dclk,
    input  logic       i_clr,
    input  logic       i_play,
    input  logic       i_tick,
    input  logic       i_fire,
    input  logic [9:0] i_ship_x,
    input  logic [9:0] i_ship_y,
    input  logic       i_hit,
    output logic [9:0] o_projectiles_x,
    output logic [9:0] o_projectiles_y,
    output logic       o_active,
    output logic [7:0] o_shots
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLIGHT   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam int CW = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    localparam logic [9:0]    SPEED_V     = 10'(SPEED);
    localparam logic [9:0]    SPAWN_V     = 10'(SPAWN_OFS);
    localparam logic [9:0]    PARK_X_V    = 10'(PARK_X);
    localparam logic [9:0]    PARK_Y_V    = 10'(PARK_Y);
    // Retire bound kept one bit wider so TOP_Y + SPEED cannot wrap.
    localparam logic [10:0]   RETIRE_LIM  = 11'(TOP_Y + SPEED);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(COOLDOWN_TICKS);
    localparam logic [CW-1:0] COOL_ONE    = CW'(1);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cool;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_active;
    logic [7:0]    r_shots;

    logic          w_press;
    logic          w_launch;
    logic          w_retire;
    logic [9:0]    w_spawn_y;

    // Two-flop synchroniser for the asynchronous button, plus one delay flop for edge detect.
    always_ff @(posedge i_dclk or negedge i_clr) begin
        if (!i_clr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_fire;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_press = r_s2 & ~r_s3;

`ifdef PROJECTILE_AUTOFIRE_EN
    // A held button (synchronised level) is enough to launch from IDLE.
    assign w_launch = i_play & (w_press | r_s2);
`else
    assign w_launch = i_play & w_press;
`endif

    // Spawn clamps at the top of the screen instead of wrapping.
    assign w_spawn_y = (i_ship_y < SPAWN_V) ? 10'd0 : (i_ship_y - SPAWN_V);

    // Hit wins regardless of tick; the top-of-screen compare precedes the subtract so y never wraps.
    assign w_retire = i_hit | (i_tick & ({1'b0, r_y} < RETIRE_LIM));

    // Projectile state machine: launch, climb, retire, cooldown; play low forces IDLE but keeps shots.
    always_ff @(posedge i_dclk or negedge i_clr) begin
        if (!i_clr) begin
            r_state  <= ST_IDLE;
            r_cool   <= '0;
            r_x      <= PARK_X_V;
            r_y      <= PARK_Y_V;
            r_active <= 1'b0;
            r_shots  <= 8'd0;
        end else if (!i_play) begin
            r_state  <= ST_IDLE;
            r_cool   <= '0;
            r_x      <= PARK_X_V;
            r_y      <= PARK_Y_V;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state  <= ST_FLIGHT;
                        r_x      <= i_ship_x;
                        r_y      <= w_spawn_y;
                        r_active <= 1'b1;
                        r_shots  <= r_shots + 8'd1;
                    end
                end
                ST_FLIGHT: begin
                    if (w_retire) begin
                        r_state  <= ST_COOLDOWN;
                        r_cool   <= COOL_LOAD;
                        r_x      <= PARK_X_V;
                        r_y      <= PARK_Y_V;
                        r_active <= 1'b0;
                    end else if (i_tick) begin
                        r_y <= r_y - SPEED_V;
                    end
                end
                ST_COOLDOWN: begin
                    if (r_cool == '0) begin
                        r_state <= ST_IDLE;
                    end else if (i_tick) begin
                        r_cool <= r_cool - COOL_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cool   <= '0;
                    r_x      <= PARK_X_V;
                    r_y      <= PARK_Y_V;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_projectiles_x = r_x;
    assign o_projectiles_y = r_y;
    assign o_active        = r_active;
    assign o_shots         = r_shots;

endmodule
